// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
//   Shared definitions for the sobel frame controller: FSM state encoding,
//   width of the result counter and the smallest frame height the sobel core
//   can produce any output for.
// -----------------------------------------------------------------------------
package sobel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Result counter width: holds (WIDTH-2)*(height-2) for any 16-bit height
  // at the default line length.
  localparam int CNT_W = 24;

  // A 3x3 window needs at least three rows.
  localparam int MIN_HEIGHT = 3;

endpackage

// File: rtl/sobel_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_frame_ctrl
//   Streams one frame from source memory through an external sobel core and
//   writes the core results to destination memory.
//
//   Ports
//     clk, rst                 rising-edge clock, synchronous active-high reset
//     start                    single-cycle frame request (ignored while busy)
//     height, src_base,        frame rows and base addresses, latched on start
//     dst_base
//     hold                     pause: suppresses new reads while high
//     busy, done, bad_cfg      status; done and bad_cfg are one-cycle pulses
//     rd_en/rd_addr/rd_data    source memory, 1-cycle read latency
//     core_rst/core_valid/     drive the sobel core
//     core_pixel
//     core_valid_out/          sobel core result
//     core_pixel_out
//     wr_en/wr_addr/wr_data    destination memory write
// -----------------------------------------------------------------------------
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       height,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              bad_cfg,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              core_rst,
  output logic              core_valid,
  output logic [7:0]        core_pixel,
  input  logic              core_valid_out,
  input  logic [7:0]        core_pixel_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  state_t            r_state;
  state_t            w_next_state;

  logic [15:0]       r_height;
  logic [ADDR_W-1:0] r_src_base;
  logic [ADDR_W-1:0] r_dst_base;
  logic              r_bad;

  logic [ADDR_W-1:0] r_rd_idx;
  logic [ADDR_W-1:0] r_rd_total;
  logic [CNT_W-1:0]  r_out_cnt;
  logic [CNT_W-1:0]  r_out_total;

  logic              r_core_valid;
  logic              r_core_valid_d;

  logic              w_rd_last;
  logic              w_accept;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  assign w_rd_last = (r_rd_idx == r_rd_total - ADDR_W'(1));

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first keeps every path driven, so no latch
  // is inferred for w_next_state.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = (height < 16'(MIN_HEIGHT)) ? ST_DONE : ST_CLEAR;
        end
      end
      ST_CLEAR: w_next_state = ST_READ;
      ST_READ: begin
        if (rd_en && w_rd_last) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_out_cnt == r_out_total) w_next_state = ST_DONE;
      end
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: latched configuration, indices and the core-valid pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_height       <= '0;
      r_src_base     <= '0;
      r_dst_base     <= '0;
      r_bad          <= 1'b0;
      r_rd_idx       <= '0;
      r_rd_total     <= '0;
      r_out_cnt      <= '0;
      r_out_total    <= '0;
      r_core_valid   <= 1'b0;
      r_core_valid_d <= 1'b0;
    end else begin
      r_core_valid   <= rd_en;
      r_core_valid_d <= r_core_valid;

      if (r_state == ST_IDLE && start) begin
        r_height   <= height;
        r_src_base <= src_base;
        r_dst_base <= dst_base;
        r_bad      <= (height < 16'(MIN_HEIGHT));
        r_rd_idx   <= '0;
        r_out_cnt  <= '0;
      end

      // Height products are formed once here so READ/DRAIN only compare.
      if (r_state == ST_CLEAR) begin
        r_rd_total  <= ADDR_W'(WIDTH * int'(r_height));
        r_out_total <= CNT_W'((WIDTH - 2) * int'(r_height - 16'd2));
      end

      if (rd_en)    r_rd_idx  <= r_rd_idx + ADDR_W'(1);
      if (w_accept) r_out_cnt <= r_out_cnt + CNT_W'(1);
    end
  end

  // The core holds valid_out while it receives nothing, so a result is new
  // only when a pixel entered the core on the previous cycle.
  assign w_accept = core_valid_out && r_core_valid_d &&
                    (r_state == ST_READ || r_state == ST_DRAIN);

  assign rd_en      = (r_state == ST_READ) && !hold;
  assign rd_addr    = r_src_base + r_rd_idx;

  assign core_rst   = rst || (r_state == ST_CLEAR);
  assign core_valid = r_core_valid;
  assign core_pixel = rd_data;

  assign wr_en      = w_accept;
  assign wr_addr    = r_dst_base + ADDR_W'(r_out_cnt);
  assign wr_data    = core_pixel_out;

  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign bad_cfg    = (r_state == ST_DONE) && r_bad;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sobel_frame_ctrl
//   Drives sobel_frame_ctrl with a behavioural source memory, a behavioural
//   sobel core (holds valid_out while idle) and a write collector. Expected
//   writes come from a direct 3x3 sobel evaluation of the source image.
// -----------------------------------------------------------------------------
module tb_sobel_frame_ctrl;

  localparam int WIDTH  = 128;
  localparam int ADDR_W = 24;
  localparam int MAXH   = 6;
  localparam int MAXPIX = WIDTH * MAXH;

  typedef int win_t [9];

  logic              clk = 1'b0;
  logic              rst, start, hold;
  logic [15:0]       height;
  logic [ADDR_W-1:0] src_base, dst_base;
  logic              busy, done, bad_cfg;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data = 8'd0;
  logic              core_rst, core_valid;
  logic [7:0]        core_pixel;
  logic              core_valid_out = 1'b0;
  logic [7:0]        core_pixel_out = 8'd0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  always #5 clk = ~clk;

  sobel_frame_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .height(height),
    .src_base(src_base), .dst_base(dst_base), .hold(hold),
    .busy(busy), .done(done), .bad_cfg(bad_cfg),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .core_rst(core_rst), .core_valid(core_valid), .core_pixel(core_pixel),
    .core_valid_out(core_valid_out), .core_pixel_out(core_pixel_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sobel9(input win_t p);
    int gx, gy, m;
    gx = (p[2] + 2 * p[5] + p[8]) - (p[0] + 2 * p[3] + p[6]);
    gy = (p[6] + 2 * p[7] + p[8]) - (p[0] + 2 * p[1] + p[2]);
    m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  // ---------------------------------------------------------------------------
  // Source memory: image held at cur_src, one-cycle read latency
  // ---------------------------------------------------------------------------
  logic [7:0]        img [MAXPIX];
  logic [ADDR_W-1:0] cur_src = '0;
  logic [ADDR_W-1:0] rd_off;
  int                oob_cnt = 0;

  assign rd_off = rd_addr - cur_src;

  always @(posedge clk) begin
    if (rd_en) begin
      if (rd_off < ADDR_W'(MAXPIX)) rd_data <= img[rd_off];
      else begin
        rd_data <= 8'd0;
        oob_cnt <= oob_cnt + 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sobel core: stores incoming pixels, emits one result per full window one
  // cycle after the pixel arrives, and holds its outputs when idle.
  // ---------------------------------------------------------------------------
  logic [7:0] core_frame [MAXPIX];
  int         core_cnt = 0;

  function automatic int core_px(input int idx);
    return (idx == core_cnt) ? int'(core_pixel) : int'(core_frame[idx]);
  endfunction

  function automatic int core_result();
    win_t p;
    int   tl;
    tl = core_cnt - 2 * WIDTH - 2;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[r * 3 + c] = core_px(tl + r * WIDTH + c);
    return sobel9(p);
  endfunction

  always @(posedge clk) begin
    if (core_rst) begin
      core_cnt       <= 0;
      core_valid_out <= 1'b0;
      core_pixel_out <= 8'd0;
    end else if (core_valid) begin
      if (core_cnt < MAXPIX) core_frame[core_cnt] <= core_pixel;
      core_cnt <= core_cnt + 1;
      if (core_cnt / WIDTH >= 2 && core_cnt % WIDTH >= 2 && core_cnt < MAXPIX) begin
        core_valid_out <= 1'b1;
        core_pixel_out <= 8'(core_result());
      end else begin
        core_valid_out <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output monitor (sampled on the falling edge)
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] wq_addr [$];
  logic [7:0]        wq_data [$];
  int cyc = 0, rd_cnt = 0, done_cnt = 0, bad_cnt = 0, done_cyc = 0;
  int hold_viol = 0, orphan_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
    if (rd_en)          rd_cnt    <= rd_cnt + 1;
    if (rd_en && hold)  hold_viol <= hold_viol + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (bad_cfg)          bad_cnt    <= bad_cnt + 1;
    if (bad_cfg && !done) orphan_bad <= orphan_bad + 1;
  end

  // ---------------------------------------------------------------------------
  // Reference model and stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic int ref_pix(input int k);
    win_t p;
    int   r0, c0;
    r0 = k / (WIDTH - 2);
    c0 = k % (WIDTH - 2);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[r * 3 + c] = int'(img[(r0 + r) * WIDTH + c0 + c]);
    return sobel9(p);
  endfunction

  // mode 0: flat 50, mode 1: left half 0 / right half 255, mode 2: random
  task automatic fill_img(input int mode);
    for (int i = 0; i < MAXPIX; i++) begin
      case (mode)
        0:       img[i] = 8'd50;
        1:       img[i] = ((i % WIDTH) < 64) ? 8'd0 : 8'd255;
        default: img[i] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  task automatic run_frame(input string tag, input int h,
                           input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                           input bit rand_hold, input int glitch_at, input int abort_at,
                           output longint sig);
    int  rd0, done0, bad0, wq0, start_cyc, n_wr, exp_rd, exp_wr, errs_a, errs_d;
    bit  seen;
    logic [ADDR_W-1:0] ea;
    sig   = 0;
    rd0   = rd_cnt;
    done0 = done_cnt;
    bad0  = bad_cnt;
    wq0   = wq_data.size();
    cur_src = src;

    @(posedge clk); #1;
    start = 1'b1; height = 16'(h); src_base = src; dst_base = dst;
    start_cyc = cyc;
    @(posedge clk); #1;
    // Scramble the config inputs: the controller must work from its latched copy.
    start = 1'b0;
    height = 16'($urandom_range(0, 65535));
    src_base = ADDR_W'($urandom);
    dst_base = ADDR_W'($urandom);

    seen = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk); #1;
      if (i == 0) check({tag, "_busy_after_start"}, busy, 1);
      if (done_cnt != done0) begin
        seen = 1'b1;
        break;
      end
      if (abort_at >= 0 && rd_cnt - rd0 >= abort_at) begin
        @(posedge clk); #1;
        rst = 1'b1; hold = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_core_rst_in_rst"}, core_rst, 1);
        check({tag, "_busy_in_rst"}, busy, 0);
        check({tag, "_rd_en_in_rst"}, rd_en, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check({tag, "_no_done_after_abort"}, done_cnt - done0, 0);
        check({tag, "_idle_after_abort"}, busy, 0);
        return;
      end
      @(posedge clk); #1;
      hold  = rand_hold ? 1'($urandom_range(0, 1)) : 1'b0;
      start = (i == glitch_at);
    end
    hold  = 1'b0;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    exp_rd = (h < 3) ? 0 : WIDTH * h;
    exp_wr = (h < 3) ? 0 : (WIDTH - 2) * (h - 2);
    n_wr   = wq_data.size() - wq0;
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_done_pulses"}, done_cnt - done0, 1);
    check({tag, "_bad_cfg_pulses"}, bad_cnt - bad0, (h < 3) ? 1 : 0);
    check({tag, "_reads"}, rd_cnt - rd0, exp_rd);
    check({tag, "_writes"}, n_wr, exp_wr);
    check({tag, "_idle_after_done"}, busy, 0);
    if (h < 3) check({tag, "_bad_latency_le2"}, (done_cyc - start_cyc >= 1) && (done_cyc - start_cyc <= 2), 1);

    errs_a = 0;
    errs_d = 0;
    for (int k = 0; k < n_wr && k < exp_wr; k++) begin
      ea = dst + ADDR_W'(k);
      if (wq_addr[wq0 + k] !== ea) errs_a++;
      if (int'(wq_data[wq0 + k]) != ref_pix(k)) errs_d++;
      sig = sig * 31 + longint'(wq_addr[wq0 + k]) * 257 + longint'(wq_data[wq0 + k]);
    end
    check({tag, "_wr_addr_errs"}, errs_a, 0);
    check({tag, "_wr_data_errs"}, errs_d, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  longint sig_ref, sig_a, sig_b;
  int     h_r;

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    height = '0; src_base = '0; dst_base = '0;
    fill_img(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bad_cfg", bad_cfg, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_core_valid", core_valid, 0);
    check("rst_core_rst", core_rst, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Flat frame: every gradient is zero.
    fill_img(0);
    run_frame("flat_h4", 4, 24'h001000, 24'h020000, 1'b0, -1, -1, sig_a);

    // Vertical edge, no pauses, then with random pauses.
    fill_img(1);
    run_frame("edge_h3", 3, 24'h003000, 24'h040000, 1'b0, -1, -1, sig_ref);
    run_frame("edge_h3_hold", 3, 24'h003000, 24'h040000, 1'b1, -1, -1, sig_a);
    check("edge_hold_matches_nohold", sig_a, sig_ref);

    // Too few rows: immediate done with bad_cfg.
    run_frame("short_h2", 2, 24'h003000, 24'h040000, 1'b0, -1, -1, sig_a);

    // Start re-asserted mid-frame, then a second frame right after.
    run_frame("edge_glitch", 3, 24'h003000, 24'h040000, 1'b0, 100, -1, sig_a);
    check("glitch_frame_matches", sig_a, sig_ref);
    run_frame("edge_second", 3, 24'h003000, 24'h040000, 1'b0, -1, -1, sig_b);
    check("second_frame_matches", sig_b, sig_ref);

    // Reset mid-frame, then a clean frame.
    fill_img(2);
    run_frame("abort_h5", 5, 24'h000100, 24'h050000, 1'b0, -1, 300, sig_a);
    fill_img(2);
    run_frame("after_abort_h4", 4, 24'h000100, 24'h050000, 1'b1, -1, -1, sig_a);

    // Random frames; the last ones straddle the address wrap.
    for (int n = 0; n < 3; n++) begin
      fill_img(2);
      h_r = int'($urandom_range(3, MAXH));
      run_frame($sformatf("rand%0d", n), h_r, ADDR_W'($urandom),
                ADDR_W'($urandom), 1'b1, -1, -1, sig_a);
    end
    fill_img(2);
    run_frame("wrap_h4", 4, 24'hFFFF80, 24'hFFFFC0, 1'b1, -1, -1, sig_a);

    check("no_read_while_hold", hold_viol, 0);
    check("bad_cfg_only_with_done", orphan_bad, 0);
    check("reads_in_image", oob_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
